// File: rtl/bram_initiator_if.sv
// bram_initiator_if: request/response handshake bundle between an upstream requester (master)
// and bram_initiator (slave).
interface bram_initiator_if #(
   parameter int RAM_WIDTH = 32,
   parameter int RAM_DEPTH = 1024
);
   localparam int AW = $clog2(RAM_DEPTH);

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [AW-1:0]        req_addr;
   logic [RAM_WIDTH-1:0] req_wstrb;
   logic [RAM_WIDTH-1:0] req_wdata;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [RAM_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/bram_initiator.sv
// bram_initiator: single-port BRAM front end, zero-latency issue path, 2-entry read-response FIFO.
// Define BRAM_INITIATOR_FILL_EN to compile in the post-reset fill engine (writes FILL_PATTERN everywhere).
module bram_initiator #(
   parameter int                   RAM_WIDTH    = 32,
   parameter int                   RAM_DEPTH    = 1024,
   parameter logic [RAM_WIDTH-1:0] FILL_PATTERN = {RAM_WIDTH{1'b0}},
   localparam int                  AW           = $clog2(RAM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rstn,
   bram_initiator_if.slave      bus,
   output logic                 ram_cs,
   output logic                 ram_we,
   output logic [AW-1:0]        ram_addr,
   output logic [RAM_WIDTH-1:0] ram_wstrb,
   output logic [RAM_WIDTH-1:0] ram_din,
   input  logic [RAM_WIDTH-1:0] ram_dout,
   input  logic                 ram_ready,
   output logic                 init_busy
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_FILL = 1'b1
   } state_t;

`ifdef BRAM_INITIATOR_FILL_EN
   localparam state_t RESET_STATE = ST_FILL;
`else
   localparam state_t RESET_STATE = ST_RUN;
`endif

   localparam logic [AW-1:0] FILL_LAST = AW'(RAM_DEPTH - 1);

   state_t               state_r;
   logic [AW-1:0]        fill_cnt_r;
   logic                 rd_inflight_r;
   logic [RAM_WIDTH-1:0] fifo_mem_r [0:1];
   logic                 fifo_wr_ptr_r;
   logic                 fifo_rd_ptr_r;
   logic [1:0]           fifo_cnt_r;

   logic                 run_s;
   logic                 fill_s;
   logic [1:0]           outstanding_s;
   logic                 credit_ok_s;
   logic                 req_ready_s;
   logic                 req_acc_s;
   logic                 rd_issue_s;
   logic                 fill_issue_s;
   logic                 rsp_valid_s;
   logic [RAM_WIDTH-1:0] rsp_rdata_s;
   logic                 pop_s;
   logic                 pop_fifo_s;
   logic                 capture_s;

   // Gating with rstn keeps the RAM port and handshake quiet while reset is held.
   assign run_s         = rstn & (state_r == ST_RUN);
   assign fill_s        = rstn & (state_r == ST_FILL);
   assign outstanding_s = fifo_cnt_r + {1'b0, rd_inflight_r};
   assign credit_ok_s   = (outstanding_s < 2'd2);
   assign req_ready_s   = run_s & ram_ready & (bus.req_we | credit_ok_s);
   assign req_acc_s     = bus.req_valid & req_ready_s;
   assign rd_issue_s    = req_acc_s & ~bus.req_we;
   assign fill_issue_s  = fill_s & ram_ready;

   assign bus.req_ready = req_ready_s;
   assign bus.rsp_valid = rsp_valid_s;
   assign bus.rsp_rdata = rsp_rdata_s;

`ifdef BRAM_INITIATOR_FILL_EN
   assign init_busy = (state_r == ST_FILL);
`else
   assign init_busy = 1'b0;
`endif

   // RAM port drive: fill write, accepted request, or all-zero idle.
   always_comb begin
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = {AW{1'b0}};
      ram_wstrb = {RAM_WIDTH{1'b0}};
      ram_din   = {RAM_WIDTH{1'b0}};
      if (fill_issue_s) begin
         ram_cs    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = fill_cnt_r;
         ram_wstrb = {RAM_WIDTH{1'b1}};
         ram_din   = FILL_PATTERN;
      end else if (req_acc_s) begin
         ram_cs    = 1'b1;
         ram_we    = bus.req_we;
         ram_addr  = bus.req_addr;
         ram_wstrb = bus.req_we ? bus.req_wstrb : {RAM_WIDTH{1'b0}};
         ram_din   = bus.req_we ? bus.req_wdata : {RAM_WIDTH{1'b0}};
      end else begin
         ram_cs    = 1'b0;
      end
   end

   // Response head: FIFO entry first, else bypass of the read returning this cycle.
   always_comb begin
      rsp_valid_s = 1'b0;
      rsp_rdata_s = {RAM_WIDTH{1'b0}};
      if (fifo_cnt_r != 2'd0) begin
         rsp_valid_s = 1'b1;
         rsp_rdata_s = fifo_mem_r[fifo_rd_ptr_r];
      end else if (rd_inflight_r) begin
         rsp_valid_s = 1'b1;
         rsp_rdata_s = ram_dout;
      end else begin
         rsp_valid_s = 1'b0;
         rsp_rdata_s = {RAM_WIDTH{1'b0}};
      end
   end

   // A bypassed response consumed in its return cycle never enters the FIFO.
   assign pop_s      = rsp_valid_s & bus.rsp_ready;
   assign pop_fifo_s = pop_s & (fifo_cnt_r != 2'd0);
   assign capture_s  = rd_inflight_r & ~(pop_s & (fifo_cnt_r == 2'd0));

   // Read-in-flight flag and 2-entry response FIFO.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_inflight_r <= 1'b0;
         fifo_mem_r[0] <= {RAM_WIDTH{1'b0}};
         fifo_mem_r[1] <= {RAM_WIDTH{1'b0}};
         fifo_wr_ptr_r <= 1'b0;
         fifo_rd_ptr_r <= 1'b0;
         fifo_cnt_r    <= 2'd0;
      end else begin
         rd_inflight_r <= rd_issue_s;
         if (capture_s) begin
            fifo_mem_r[fifo_wr_ptr_r] <= ram_dout;
            fifo_wr_ptr_r             <= ~fifo_wr_ptr_r;
         end
         if (pop_fifo_s) begin
            fifo_rd_ptr_r <= ~fifo_rd_ptr_r;
         end
         case ({capture_s, pop_fifo_s})
            2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
            2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
            default: fifo_cnt_r <= fifo_cnt_r;
         endcase
      end
   end

   // FILL/RUN state machine; the fill counter saturates at the last word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= RESET_STATE;
         fill_cnt_r <= {AW{1'b0}};
      end else begin
         case (state_r)
            ST_FILL: begin
               if (ram_ready) begin
                  if (fill_cnt_r == FILL_LAST) begin
                     state_r <= ST_RUN;
                  end else begin
                     fill_cnt_r <= fill_cnt_r + {{(AW-1){1'b0}}, 1'b1};
                  end
               end
            end
            ST_RUN:  state_r <= ST_RUN;
            default: state_r <= RESET_STATE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_initiator.sv
// tb_bram_initiator: randomized + directed bench with a queue/array reference model and a simple RAM.
module tb_bram_initiator;
`ifdef BRAM_INITIATOR_FILL_EN
   localparam int          DEPTH = 16;
   localparam logic [31:0] PAT   = 32'hA5A5A5A5;
   localparam bit          FILL  = 1'b1;
`else
   localparam int          DEPTH = 1024;
   localparam logic [31:0] PAT   = 32'h00000000;
   localparam bit          FILL  = 1'b0;
`endif
   localparam int W  = 32;
   localparam int AW = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          ram_cs, ram_we, ram_ready, init_busy;
   logic [AW-1:0] ram_addr;
   logic [W-1:0]  ram_wstrb, ram_din, ram_dout;

   bram_initiator_if #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH)) bus ();

   bram_initiator #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .FILL_PATTERN(PAT)) dut (
      .clk(clk), .rstn(rstn), .bus(bus),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wstrb(ram_wstrb),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_ready(ram_ready), .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] init_word(input int a);
      return 32'hC0DE0000 ^ (a * 32'h00009E37);
   endfunction

   // Simple RAM: dout valid the cycle after a read, garbage otherwise.
   logic [W-1:0] ram_mem [DEPTH];
   bit           ram_written [DEPTH];
   always @(posedge clk) begin
      if (ram_cs && ram_we) begin
         ram_mem[ram_addr] <= ((ram_written[ram_addr] ? ram_mem[ram_addr] : init_word(int'(ram_addr)))
                               & ~ram_wstrb) | (ram_din & ram_wstrb);
         ram_written[ram_addr] <= 1'b1;
      end
      if (ram_cs && !ram_we)
         ram_dout <= ram_written[ram_addr] ? ram_mem[ram_addr] : init_word(int'(ram_addr));
      else
         ram_dout <= $urandom;
   end

   // Reference model state
   logic [W-1:0] shadow [DEPTH];
   logic [W-1:0] q [$];
   logic [W-1:0] got_q [$];
   int           fill_idx = DEPTH;
   int           busy_cnt = 0;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_got(input string name, input int idx, input logic [W-1:0] exp);
      if (idx < got_q.size()) chk(name, got_q[idx], exp);
      else begin
         checks++;
         errors++;
         $display("FAIL %s: response %0d missing, expected %h", name, idx, exp);
      end
   endtask

   task automatic set_req(input bit v, input bit we, input int a, input logic [W-1:0] s, input logic [W-1:0] d);
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_addr  = AW'(a);
      bus.req_wstrb = s;
      bus.req_wdata = d;
   endtask

   // One cycle: compare at negedge against the model, advance the model at posedge.
   task automatic step(output bit acc);
      logic e_rdy, e_cs, e_we, e_rv, e_busy;
      logic [AW-1:0] e_addr;
      logic [W-1:0]  e_strb, e_din, e_rd, seen;
      bit fill_act;
      @(negedge clk);
      e_rdy = 1'b0; e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_strb = '0; e_din = '0;
      fill_act = FILL && rstn && (fill_idx < DEPTH);
      if (!rstn) begin
         e_cs = 1'b0;
      end else if (fill_act) begin
         e_cs = ram_ready;
         if (ram_ready) begin
            e_we = 1'b1; e_addr = AW'(fill_idx); e_strb = '1; e_din = PAT;
         end
      end else begin
         e_rdy = ram_ready && (bus.req_we || q.size() < 2);
         e_cs  = bus.req_valid && e_rdy;
         if (e_cs) begin
            e_we = bus.req_we; e_addr = bus.req_addr;
            e_strb = bus.req_we ? bus.req_wstrb : '0;
            e_din  = bus.req_we ? bus.req_wdata : '0;
         end
      end
      e_rv   = rstn && (q.size() > 0);
      e_rd   = e_rv ? q[0] : '0;
      e_busy = FILL && (!rstn || fill_act);
      chk("req_ready", W'(bus.req_ready), W'(e_rdy));
      chk("ram_cs", W'(ram_cs), W'(e_cs));
      chk("ram_we", W'(ram_we), W'(e_we));
      if (e_cs) chk("ram_addr", W'(ram_addr), W'(e_addr));
      chk("ram_wstrb", ram_wstrb, e_strb);
      chk("ram_din", ram_din, e_din);
      chk("rsp_valid", W'(bus.rsp_valid), W'(e_rv));
      chk("rsp_rdata", bus.rsp_rdata, e_rd);
      chk("init_busy", W'(init_busy), W'(e_busy));
      seen = bus.rsp_rdata;
      if (rstn && init_busy) busy_cnt++;
      @(posedge clk);
      acc = 1'b0;
      if (!rstn) begin
         q.delete();
         fill_idx = 0;
      end else begin
         if (fill_act && ram_ready) begin
            shadow[fill_idx] = PAT;
            fill_idx++;
         end
         if (e_rv && bus.rsp_ready) begin
            got_q.push_back(seen);
            void'(q.pop_front());
         end
         if (e_cs && !fill_act) begin
            acc = 1'b1;
            if (bus.req_we)
               shadow[bus.req_addr] = (shadow[bus.req_addr] & ~bus.req_wstrb) | (bus.req_wdata & bus.req_wstrb);
            else
               q.push_back(shadow[bus.req_addr]);
         end
      end
      #1;
   endtask

   task automatic run_fill();
      ram_ready = 1'b1;
      set_req(1'b1, 1'b0, 3, '0, '0);
      repeat (DEPTH + 2) begin
         bit a;
         step(a);
      end
      set_req(1'b0, 1'b0, 0, '0, '0);
   endtask

   initial begin
      bit acc;
      int k;
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
      ram_ready = 1'b1;
      bus.rsp_ready = 1'b1;
      set_req(1'b0, 1'b0, 0, '0, '0);
      rstn = 1'b0;
      repeat (3) step(acc);
      rstn = 1'b1;

      if (FILL) begin
         // Fill interrupted at address 7, then a full restart.
         repeat (7) step(acc);
         chk("fill_idx_at_pulse", W'(fill_idx), W'(7));
         rstn = 1'b0;
         repeat (2) step(acc);
         rstn = 1'b1;
         busy_cnt = 0;
         run_fill();
         chk("busy_cycles", W'(busy_cnt), W'(DEPTH));
         got_q.delete();
         set_req(1'b1, 1'b0, 5, '0, '0);
         step(acc);
         set_req(1'b0, 1'b0, 0, '0, '0);
         repeat (3) step(acc);
         chk_got("fill_word", 0, 32'hA5A5A5A5);
      end

      // Full-strobe write then read back.
      got_q.delete();
      set_req(1'b1, 1'b1, 'h10, '1, 32'hDEADBEEF);
      step(acc);
      set_req(1'b1, 1'b0, 'h10, '0, '0);
      step(acc);
      set_req(1'b0, 1'b0, 0, '0, '0);
      repeat (3) step(acc);
      chk_got("wr_rd_0x10", 0, 32'hDEADBEEF);

      // Partial strobe merge.
      got_q.delete();
      set_req(1'b1, 1'b1, 'h20, '1, 32'hFFFFFFFF);
      step(acc);
      set_req(1'b1, 1'b1, 'h20, 32'h0000FFFF, 32'h00001234);
      step(acc);
      set_req(1'b1, 1'b0, 'h20, '0, '0);
      step(acc);
      set_req(1'b0, 1'b0, 0, '0, '0);
      repeat (3) step(acc);
      chk_got("strobe_merge", 0, 32'hFFFF1234);

      // Backpressure: only two reads accepted while rsp_ready=0.
      got_q.delete();
      bus.rsp_ready = 1'b0;
      k = 0;
      repeat (4) begin
         set_req(1'b1, 1'b0, k, '0, '0);
         step(acc);
         if (acc) k++;
      end
      chk("bp_accepted", W'(k), W'(2));
      bus.rsp_ready = 1'b1;
      for (int t = 0; t < 20 && k < 4; t++) begin
         set_req(1'b1, 1'b0, k, '0, '0);
         step(acc);
         if (acc) k++;
      end
      set_req(1'b0, 1'b0, 0, '0, '0);
      repeat (4) step(acc);
      chk("bp_all_accepted", W'(k), W'(4));
      for (int i = 0; i < 4; i++) chk_got("bp_order", i, shadow[i]);

      // ram_ready low for 3 cycles within a read stream.
      got_q.delete();
      k = 0;
      for (int t = 0; t < 40 && k < 10; t++) begin
         ram_ready = !(t >= 3 && t < 6);
         set_req(1'b1, 1'b0, k, '0, '0);
         step(acc);
         if (acc) k++;
      end
      ram_ready = 1'b1;
      set_req(1'b0, 1'b0, 0, '0, '0);
      repeat (4) step(acc);
      chk("stall_resp_count", W'(got_q.size()), W'(10));
      for (int i = 0; i < 10; i++) chk_got("stall_order", i, shadow[i]);

      // Reset with reads outstanding discards them.
      bus.rsp_ready = 1'b0;
      set_req(1'b1, 1'b0, 1, '0, '0);
      repeat (2) step(acc);
      set_req(1'b0, 1'b0, 0, '0, '0);
      rstn = 1'b0;
      repeat (2) step(acc);
      rstn = 1'b1;
      bus.rsp_ready = 1'b1;
      if (FILL) run_fill();
      else step(acc);
      chk("rst_discard", W'(bus.rsp_valid), W'(0));

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 499) == 0) rstn = 1'b0;
         else rstn = 1'b1;
         ram_ready     = ($urandom_range(0, 9) < 8);
         bus.rsp_ready = ($urandom_range(0, 9) < 7);
         set_req($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1) ? {W{1'b1}} : W'($urandom), W'($urandom));
         step(acc);
      end
      rstn = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bram_initiator.md
BRAM_INITIATOR -- requirements
Module: bram_initiator

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 32, data and bit-strobe width.
REQ-002 SHALL have parameter RAM_DEPTH, default 1024, word count; AW = $clog2(RAM_DEPTH).
REQ-003 SHALL have parameter FILL_PATTERN, default 0, RAM_WIDTH-bit word written by the fill engine.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn  in  1  reset, asynchronous and active-low.
REQ-006 req_valid  in  1  upstream request present.
REQ-007 req_ready  out  1  request accepted when req_valid&req_ready.
REQ-008 req_we  in  1  1=write, 0=read.
REQ-009 req_addr  in  AW  word address.
REQ-010 req_wstrb  in  RAM_WIDTH  per-bit write enable.
REQ-011 req_wdata  in  RAM_WIDTH  write data.
REQ-012 rsp_valid  out  1  read data available.
REQ-013 rsp_ready  in  1  downstream takes data when rsp_valid&rsp_ready.
REQ-014 rsp_rdata  out  RAM_WIDTH  read data.
REQ-015 ram_cs, ram_we  out  1 each  RAM chip select, write enable.
REQ-016 ram_addr  out  AW  RAM address.
REQ-017 ram_wstrb, ram_din  out  RAM_WIDTH each  RAM bit strobe, write data.
REQ-018 ram_dout  in  RAM_WIDTH  RAM read data, valid the cycle after a read issue.
REQ-019 ram_ready  in  1  RAM accepts an access this cycle.
REQ-020 init_busy  out  1  fill engine active; requests blocked.

Function
REQ-021 States FILL and RUN; RUN accepts requests, FILL runs the fill engine only.
REQ-022 In RUN, ram_cs=req_valid&req_ready; ram_we/addr/wstrb/din pass req_* combinationally (zero issue latency).
REQ-023 req_ready = RUN & ram_ready & (req_we | credits>0); credits = 2 - (rsp FIFO occupancy + read in flight).
REQ-024 Read issued at cycle N: ram_dout captured into 2-entry response FIFO at edge N+1; rsp_valid earliest cycle N+1.
REQ-025 ram_dout SHALL be captured only in the cycle after a read issue; never after a write or idle cycle.
REQ-026 Writes generate no response; writes SHALL be accepted while FIFO full.
REQ-027 Responses returned strictly in issue order.
REQ-028 Simultaneous capture and pop: occupancy unchanged, data ordering preserved.
REQ-029 Back-to-back reads, rsp_ready=1: one read accepted and one response delivered per cycle.
REQ-030 rsp_ready=0: after two reads outstanding, req_ready=0 for reads until a pop.
REQ-031 ram_ready=0: req_ready=0, ram_cs=0, no state change except FIFO pops.
REQ-032 Outside accepted accesses ram_cs=0; ram_we, ram_wstrb, ram_din SHALL be 0.

Reset
REQ-033 On rstn low: req_ready=0, rsp_valid=0, ram_cs=0, FIFO empty, read-in-flight flag cleared, fill counter 0.
REQ-034 Reset asserted mid-fill or mid-read SHALL discard all in-flight data; fill restarts at address 0 after release.
REQ-035 rsp_rdata SHALL be 0 while rsp_valid=0.

Configuration
REQ-036 Macro BRAM_INITIATOR_FILL_EN compiles in the fill engine.
REQ-037 With macro: reset enters FILL; each cycle ram_ready=1 writes FILL_PATTERN, all-ones strobe, to counter address, counter increments.
REQ-038 With macro: write to RAM_DEPTH-1 moves to RUN next cycle; counter does not wrap; init_busy=1 exactly in FILL.
REQ-039 Without macro: reset enters RUN directly, FILL unreachable, init_busy tied 0.

Verification
REQ-040 Write addr 0x10 data 0xDEADBEEF strobe all-ones, then read 0x10 -> rsp_rdata=0xDEADBEEF one cycle after read issue.
REQ-041 Write 0x20 data 0xFFFFFFFF, then strobe 0x0000FFFF data 0x00001234; read -> 0xFFFF1234.
REQ-042 rsp_ready=0, four reads to 0..3 offered -> two accepted, req_ready=0; release -> data in order 0,1, then 2,3.
REQ-043 ram_ready low 3 cycles during read stream -> no ram_cs, no response lost or duplicated.
REQ-044 BRAM_INITIATOR_FILL_EN, RAM_DEPTH=16, FILL_PATTERN=0xA5A5A5A5 -> init_busy 16 cycles, then every read returns 0xA5A5A5A5.
REQ-045 rstn pulsed at fill address 7 -> fill restarts at 0, init_busy=1 for full RAM_DEPTH cycles.
